seq_bit_serializer: RTL and testbench

//  Upstream feeder for the sequence detector. Accepts parallel words over a

---
 rtl/seq_bit_serializer.sv | 116 +++++++++++
 tb/tb_seq_bit_serializer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial feeder for the sequence detector.
// One-entry holding register lets consecutive words stream without gaps.
module seq_bit_serializer #(
  parameter int   WIDTH     = 8,
  parameter int   LSB_FIRST = 0,
  parameter logic IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             x,
  output logic             x_valid,
  output logic             frame_done,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shifter_q, shifter_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             x_q, x_d;
  logic             x_valid_q, x_valid_d;
  logic             frame_done_q, frame_done_d;

  logic             accept;
  logic             last;
  logic             load;

  // reset gating keeps din_ready low while reset is held
  assign din_ready = reset & ~hold_full_q;
  assign accept    = din_valid & din_ready;
  assign last      = (cnt_q == LAST_CNT);
  assign load      = (state_q == IDLE) | last;

  always_comb begin
    state_d     = state_q;
    shifter_d   = shifter_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    cnt_d       = cnt_q;
    if (load) begin
      unique case (1'b1)
        hold_full_q: begin
          shifter_d   = hold_q;
          hold_full_d = 1'b0;
          cnt_d       = '0;
          state_d     = SHIFT;
        end
        accept: begin
          shifter_d = din;
          cnt_d     = '0;
          state_d   = SHIFT;
        end
        default: state_d = IDLE;
      endcase
    end else begin
      if (LSB_FIRST != 0)
        shifter_d = {1'b0, shifter_q[WIDTH-1:1]};
      else
        shifter_d = {shifter_q[WIDTH-2:0], 1'b0};
      cnt_d = cnt_q + CW'(1);
      if (accept) begin
        hold_d      = din;
        hold_full_d = 1'b1;
      end
    end
  end

  // outputs are registered from next-state values
  always_comb begin
    x_valid_d    = (state_d == SHIFT);
    frame_done_d = x_valid_d & (cnt_d == LAST_CNT);
    x_d          = IDLE_BIT;
    if (x_valid_d)
      x_d = (LSB_FIRST != 0) ? shifter_d[0] : shifter_d[WIDTH-1];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      shifter_q    <= '0;
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      cnt_q        <= '0;
      x_q          <= IDLE_BIT;
      x_valid_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shifter_q    <= shifter_d;
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      cnt_q        <= cnt_d;
      x_q          <= x_d;
      x_valid_q    <= x_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign x          = x_q;
  assign x_valid    = x_valid_q;
  assign frame_done = frame_done_q;
  assign busy       = (state_q == SHIFT) | hold_full_q;

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Scoreboard bench for seq_bit_serializer (WIDTH=4, MSB- and LSB-first).
// Expected bits are queued on accept; monitors pop on every x_valid cycle.
module tb_seq_bit_serializer;

  logic       clk;
  logic       reset;
  logic [3:0] din, din2;
  logic       din_valid, din_valid2;
  logic       din_ready, din_ready2;
  logic       x, x2;
  logic       x_valid, x_valid2;
  logic       frame_done, frame_done2;
  logic       busy, busy2;

  int checks = 0;
  int errors = 0;

  logic [1:0] q[$];
  logic [1:0] q2[$];

  int         run, maxrun, zcnt;
  logic [3:0] hist;
  bit         seen_nr;

  seq_bit_serializer #(.WIDTH(4), .LSB_FIRST(0), .IDLE_BIT(1'b0)) dut (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .x(x), .x_valid(x_valid),
    .frame_done(frame_done), .busy(busy)
  );

  seq_bit_serializer #(.WIDTH(4), .LSB_FIRST(1), .IDLE_BIT(1'b0)) dut_lsb (
    .clk(clk), .reset(reset), .din(din2), .din_valid(din_valid2),
    .din_ready(din_ready2), .x(x2), .x_valid(x_valid2),
    .frame_done(frame_done2), .busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor + bit-level 1101 detector model for the MSB-first instance
  always @(negedge clk) begin
    logic [1:0] e;
    if (!reset) begin
      run = 0; maxrun = 0; zcnt = 0; hist = 4'b0;
    end else if (x_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_bit", 1, 0);
      end else begin
        e = q.pop_front();
        chk("x_bit", {31'b0, x}, {31'b0, e[1]});
        chk("frame_done", {31'b0, frame_done}, {31'b0, e[0]});
      end
      run++;
      if (run > maxrun) maxrun = run;
      hist = {hist[2:0], x};
      if (hist == 4'b1101) zcnt++;
    end else begin
      run = 0;
      chk("idle_frame_done", {31'b0, frame_done}, 0);
    end
  end

  always @(negedge clk) begin
    logic [1:0] e;
    if (reset && x_valid2) begin
      if (q2.size() == 0) begin
        chk("lsb_unexpected_bit", 1, 0);
      end else begin
        e = q2.pop_front();
        chk("lsb_x_bit", {31'b0, x2}, {31'b0, e[1]});
        chk("lsb_frame_done", {31'b0, frame_done2}, {31'b0, e[0]});
      end
    end
  end

  // exp holds the hand-computed bit sequence, exp[3] goes out first
  task automatic send(input bit sel, input logic [3:0] w,
                      input logic [3:0] exp);
    int n = 0;
    logic rdy;
    @(negedge clk);
    if (sel) begin din2 = w; din_valid2 = 1'b1; end
    else     begin din  = w; din_valid  = 1'b1; end
    rdy = sel ? din_ready2 : din_ready;
    while (!rdy && n < 50) begin
      seen_nr = 1'b1;
      @(negedge clk);
      n++;
      rdy = sel ? din_ready2 : din_ready;
    end
    chk("send_ready", {31'b0, rdy}, 1);
    @(posedge clk);
    for (int i = 3; i >= 0; i--) begin
      if (sel) q2.push_back({exp[i], i == 0});
      else     q.push_back({exp[i], i == 0});
    end
  endtask

  task automatic stop();
    @(negedge clk);
    din_valid  = 1'b0;
    din_valid2 = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || q2.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_queue", q.size() + q2.size(), 0);
    @(negedge clk);
    #1;
    chk("idle_x_valid", {30'b0, x_valid, x_valid2}, 0);
    chk("idle_busy", {30'b0, busy, busy2}, 0);
    chk("idle_x", {30'b0, x, x2}, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b0;
    q.delete();
    q2.delete();
    @(negedge clk);
    #2 reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    din = 4'b1101; din_valid = 1'b1;
    din2 = 4'b1011; din_valid2 = 1'b1;
    seen_nr = 1'b0;

    // reset held 13 ns with din_valid high
    #7;
    chk("rst_x", {31'b0, x}, 0);
    chk("rst_x_valid", {31'b0, x_valid}, 0);
    chk("rst_din_ready", {30'b0, din_ready, din_ready2}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    #6;
    reset = 1'b1; din_valid = 1'b0; din_valid2 = 1'b0;
    #1;
    chk("post_rst_ready", {30'b0, din_ready, din_ready2}, 2'b11);
    @(negedge clk);
    #1;
    chk("post_rst_no_word", {29'b0, x_valid, busy, x_valid2}, 0);

    // single word
    send(0, 4'b1101, 4'b1101);
    stop();
    drain();

    // back-to-back stream of three words
    do_reset();
    seen_nr = 1'b0;
    send(0, 4'b1101, 4'b1101);
    send(0, 4'b1011, 4'b1011);
    send(0, 4'b0110, 4'b0110);
    stop();
    drain();
    chk("b2b_contiguous", maxrun, 12);
    chk("b2b_ready_drop", {31'b0, seen_nr}, 1);

    // mid-word reset with a word held
    send(0, 4'b1101, 4'b1101);
    send(0, 4'b0110, 4'b0110);
    stop();
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_x_valid", {31'b0, x_valid}, 0);
    chk("mid_rst_x", {31'b0, x}, 0);
    chk("mid_rst_frame_done", {31'b0, frame_done}, 0);
    chk("mid_rst_busy", {31'b0, busy}, 0);
    chk("mid_rst_ready", {31'b0, din_ready}, 0);
    q.delete();
    @(negedge clk);
    #2 reset = 1'b1;
    begin
      int nv = 0;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        #1;
        if (x_valid || busy) nv++;
      end
      chk("mid_rst_residual", nv, 0);
    end
    chk("mid_rst_release_ready", {31'b0, din_ready}, 1);

    // detector integration: 1101 occurs three times, overlapping
    send(0, 4'b1101, 4'b1101);
    send(0, 4'b1011, 4'b1011);
    send(0, 4'b0110, 4'b0110);
    stop();
    drain();
    chk("det_z_count", zcnt, 3);
    chk("det_contiguous", maxrun, 12);

    // LSB-first instance: 1011 goes out as 1,1,0,1
    send(1, 4'b1011, 4'b1101);
    stop();
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
